// File: rtl/syzygy_camera_pkg.sv
// Shared types and constants for the camera capture controller.
// Holds the FSM state encoding and the AXIS beat width.
package syzygy_camera_pkg;

    localparam int BEAT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_ACTIVE   = 2'd2,
        S_DROP     = 2'd3
    } state_t;

endpackage

// File: rtl/syzygy_camera_beat_hold.sv
// One-entry beat hold register feeding the AXIS output.
// Delays each beat by one so the frame's last beat can carry tlast.
module syzygy_camera_beat_hold
    import syzygy_camera_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [BEAT_W-1:0] data_i,
    input  logic              eof_i,
    output logic [BEAT_W-1:0] tdata_o,
    output logic              tvalid_o,
    output logic              tlast_o,
    output logic              pend_o,
    output logic              frame_end_o
);

    logic [BEAT_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic              pend_q, pend_d;
    logic [BEAT_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;

    // Hold/emit decision: a new beat pushes the held one out.
    always_comb begin
        hold_d      = hold_q;
        full_d      = full_q;
        pend_d      = pend_q;
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        frame_end_o = 1'b0;
        if (clr_i) begin
            full_d = 1'b0;
            pend_d = 1'b0;
        end else if (en_i) begin
            if (pend_q) begin
                tdata_d     = hold_q;
                tvalid_d    = 1'b1;
                tlast_d     = 1'b1;
                full_d      = 1'b0;
                pend_d      = 1'b0;
                frame_end_o = 1'b1;
            end else if (valid_i) begin
                if (full_q) begin
                    tdata_d  = hold_q;
                    tvalid_d = 1'b1;
                end
                hold_d = data_i;
                full_d = 1'b1;
                pend_d = eof_i;
            end else if (eof_i) begin
                if (full_q) begin
                    tdata_d  = hold_q;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                end
                full_d      = 1'b0;
                frame_end_o = 1'b1;
            end
        end
    end

    // Hold and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            full_q   <= 1'b0;
            pend_q   <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            full_q   <= full_d;
            pend_q   <= pend_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;
    assign pend_o   = pend_q;

endmodule

// File: rtl/syzygy_camera_capture_ctrl.sv
// Multi-frame capture sequencer between the HiSPi PHY and AXIS FIFO.
// Skips settling frames, gates N frames, flags overflow and timeout.
module syzygy_camera_capture_ctrl
    import syzygy_camera_pkg::*;
#(
    parameter int              TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd16_000_000
) (
    input  logic              clk,
    input  logic              reset_async_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [7:0]        num_frames_req,
    input  logic [3:0]        skip_frames,
    input  logic              pix_valid,
    input  logic [BEAT_W-1:0] pix_data,
    input  logic              sof,
    input  logic              eof,
    output logic [BEAT_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frames_captured,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - 1'b1;

    state_t          state_q, state_d;
    logic [7:0]      req_q, req_d;
    logic [3:0]      skip_q, skip_d;
    logic [7:0]      fc_q, fc_d;
    logic            eo_q, eo_d;
    logic            et_q, et_d;
    logic            done_q, done_d;
    logic            busy_q;
    logic [TO_W-1:0] to_q;

    logic            ovf;
    logic            hold_en;
    logic            hold_clr;
    logic            frame_end;
    logic            pend;
    logic            last_frame;
    logic [7:0]      fc_inc;

    assign ovf        = (state_q == S_ACTIVE) && m_axis_tvalid && !m_axis_tready;
    assign hold_en    = (state_q == S_ACTIVE);
    assign hold_clr   = abort || ovf;
    assign fc_inc     = (fc_q == 8'hFF) ? fc_q : fc_q + 8'd1;
    assign last_frame = ({1'b0, fc_q} + 9'd1) == {1'b0, req_q};

    syzygy_camera_beat_hold u_hold (
        .clk        (clk),
        .rst_n      (reset_async_n),
        .en_i       (hold_en),
        .clr_i      (hold_clr),
        .valid_i    (pix_valid),
        .data_i     (pix_data),
        .eof_i      (eof),
        .tdata_o    (m_axis_tdata),
        .tvalid_o   (m_axis_tvalid),
        .tlast_o    (m_axis_tlast),
        .pend_o     (pend),
        .frame_end_o(frame_end)
    );

    // Capture FSM next-state, counters and error flags.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        skip_d  = skip_q;
        fc_d    = fc_q;
        eo_d    = eo_q;
        et_d    = et_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        if (num_frames_req != 8'd0) begin
                            req_d   = num_frames_req;
                            skip_d  = skip_frames;
                            fc_d    = 8'd0;
                            eo_d    = 1'b0;
                            et_d    = 1'b0;
                            state_d = S_WAIT_SOF;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_WAIT_SOF: begin
                    if (sof) begin
                        if (skip_q != 4'd0) begin
                            skip_d = skip_q - 4'd1;
                        end else begin
                            state_d = S_ACTIVE;
                        end
                    end else if (to_q == TO_LAST) begin
                        et_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (ovf) begin
                        eo_d = 1'b1;
                        if (eof || pend) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (frame_end) begin
                        fc_d = fc_inc;
                        if (last_frame) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT_SOF;
                        end
                    end
                end
                S_DROP: begin
                    if (eof) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, status and timeout counter registers.
    always_ff @(posedge clk or negedge reset_async_n) begin
        if (!reset_async_n) begin
            state_q <= S_IDLE;
            req_q   <= 8'd0;
            skip_q  <= 4'd0;
            fc_q    <= 8'd0;
            eo_q    <= 1'b0;
            et_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            skip_q  <= skip_d;
            fc_q    <= fc_d;
            eo_q    <= eo_d;
            et_q    <= et_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
            to_q    <= (state_q == S_WAIT_SOF) ? to_q + 1'b1 : '0;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign frames_captured = fc_q;
    assign err_overflow    = eo_q;
    assign err_timeout     = et_q;

endmodule

// File: tb/tb_syzygy_camera_capture_ctrl.sv
// Directed bench for syzygy_camera_capture_ctrl.
// Linear stimulus with immediate assertions at each check point.
module tb_syzygy_camera_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset_async_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_frames_req = 8'd0;
    logic [3:0]  skip_frames = 4'd0;
    logic        pix_valid = 1'b0;
    logic [31:0] pix_data = 32'd0;
    logic        sof = 1'b0;
    logic        eof = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic        done;
    logic [7:0]  frames_captured;
    logic        err_overflow;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    logic [31:0] beats[$];
    int lasts = 0;
    int dones = 0;

    syzygy_camera_capture_ctrl #(
        .TO_W          (24),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk            (clk),
        .reset_async_n  (reset_async_n),
        .arm            (arm),
        .abort          (abort),
        .num_frames_req (num_frames_req),
        .skip_frames    (skip_frames),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .sof            (sof),
        .eof            (eof),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
        .done           (done),
        .frames_captured(frames_captured),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    // Record every emitted beat and done pulse.
    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            beats.push_back(m_axis_tdata);
            if (m_axis_tlast) lasts++;
        end
        if (done) dones++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        beats.delete();
        lasts = 0;
        dones = 0;
    endtask

    task automatic arm_cap(input logic [7:0] n, input logic [3:0] s);
        num_frames_req = n;
        skip_frames    = s;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base,
                              input bit co);
        sof = 1'b1;
        cyc();
        sof = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = base + 32'(i);
            eof       = co && (i == n - 1);
            cyc();
        end
        pix_valid = 1'b0;
        if (!co) begin
            eof = 1'b1;
            cyc();
        end
        eof = 1'b0;
    endtask

    initial begin
        int seen;
        int d0;
        #1;
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fc", {24'd0, frames_captured}, 32'd0);
        chk("rst_errs", {30'd0, err_overflow, err_timeout}, 32'd0);
        cyc();
        cyc();
        reset_async_n = 1'b1;
        cyc();

        // single frame of 5 beats
        clr_mon();
        arm_cap(8'd1, 4'd0);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        send_frame(5, 32'hD000_0000, 1'b0);
        chk("s1_last_beat", m_axis_tdata, 32'hD000_0004);
        chk("s1_tvl", {30'd0, m_axis_tvalid, m_axis_tlast}, 32'd3);
        chk("s1_done", {31'd0, done}, 32'd1);
        chk("s1_fc", {24'd0, frames_captured}, 32'd1);
        chk("s1_busy_end", {31'd0, busy}, 32'd0);
        cyc();
        cyc();
        chk("s1_nbeats", beats.size(), 32'd5);
        chk("s1_b0", beats[0], 32'hD000_0000);
        chk("s1_b3", beats[3], 32'hD000_0003);
        chk("s1_lasts", lasts, 32'd1);
        chk("s1_dones", dones, 32'd1);

        // skip 3 frames, capture 2
        clr_mon();
        arm_cap(8'd2, 4'd3);
        for (int f = 1; f <= 5; f++) begin
            send_frame(4, 32'(f) << 8, 1'b0);
            if (f == 4) chk("sk_f4_done", {31'd0, done}, 32'd0);
        end
        chk("sk_done", {31'd0, done}, 32'd1);
        chk("sk_fc", {24'd0, frames_captured}, 32'd2);
        cyc();
        chk("sk_nbeats", beats.size(), 32'd8);
        chk("sk_first", beats[0], 32'h400);
        chk("sk_final", beats[7], 32'h503);
        chk("sk_lasts", lasts, 32'd2);
        chk("sk_dones", dones, 32'd1);

        // overflow in frame 1
        clr_mon();
        arm_cap(8'd2, 4'd0);
        sof = 1'b1;
        cyc();
        sof = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 32'hA0;
        cyc();
        pix_data  = 32'hA1;
        cyc();
        chk("ov_tv_pre", {31'd0, m_axis_tvalid}, 32'd1);
        m_axis_tready = 1'b0;
        pix_data = 32'hA2;
        cyc();
        m_axis_tready = 1'b1;
        chk("ov_flag", {31'd0, err_overflow}, 32'd1);
        pix_data = 32'hA3;
        cyc();
        pix_valid = 1'b0;
        eof = 1'b1;
        cyc();
        eof = 1'b0;
        chk("ov_done", {31'd0, done}, 32'd1);
        chk("ov_fc", {24'd0, frames_captured}, 32'd0);
        chk("ov_busy", {31'd0, busy}, 32'd0);
        cyc();
        chk("ov_nbeats", beats.size(), 32'd1);

        // re-arm clears overflow, then abort mid-frame
        arm_cap(8'd1, 4'd0);
        chk("rearm_ovf", {31'd0, err_overflow}, 32'd0);
        sof = 1'b1;
        cyc();
        sof = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 32'hC0;
        cyc();
        pix_data  = 32'hC1;
        cyc();
        d0 = dones;
        abort = 1'b1;
        pix_data = 32'hC2;
        cyc();
        abort = 1'b0;
        pix_valid = 1'b0;
        chk("ab_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        cyc();
        cyc();
        chk("ab_nodone", dones, d0);

        // timeout after 100 cycles in WAIT_SOF
        arm_cap(8'd1, 4'd0);
        seen = 0;
        for (int i = 0; i < 99; i++) begin
            cyc();
            if (done) seen++;
        end
        chk("to_early", seen, 32'd0);
        cyc();
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {31'd0, err_timeout}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);

        // req = 0
        clr_mon();
        arm_cap(8'd0, 4'd0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd0);
        cyc();
        chk("z_done_off", {31'd0, done}, 32'd0);
        chk("z_nbeats", beats.size(), 32'd0);

        // eof coincident with last pix_valid
        clr_mon();
        arm_cap(8'd1, 4'd0);
        chk("co_to_clr", {31'd0, err_timeout}, 32'd0);
        send_frame(3, 32'hB0, 1'b1);
        chk("co_prev", {m_axis_tdata[30:0], m_axis_tlast}, {31'hB1, 1'b0});
        chk("co_done_pre", {31'd0, done}, 32'd0);
        cyc();
        chk("co_last", {m_axis_tdata[30:0], m_axis_tlast}, {31'hB2, 1'b1});
        chk("co_done", {31'd0, done}, 32'd1);
        chk("co_fc", {24'd0, frames_captured}, 32'd1);

        // arm while busy is ignored
        cyc();
        arm_cap(8'd2, 4'd0);
        arm_cap(8'd1, 4'd0);
        send_frame(2, 32'h700, 1'b0);
        chk("ab2_busy", {31'd0, busy}, 32'd1);
        chk("ab2_done", {31'd0, done}, 32'd0);
        chk("ab2_fc", {24'd0, frames_captured}, 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab2_idle", {31'd0, busy}, 32'd0);

        // async reset mid-frame
        arm_cap(8'd1, 4'd0);
        sof = 1'b1;
        cyc();
        sof = 1'b0;
        pix_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_data = 32'hE0 + 32'(i);
            cyc();
        end
        chk("rs_pre_tv", {31'd0, m_axis_tvalid}, 32'd1);
        reset_async_n = 1'b0;
        #1;
        pix_valid = 1'b0;
        chk("rs_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rs_tdata", m_axis_tdata, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_fc", {24'd0, frames_captured}, 32'd0);
        cyc();
        reset_async_n = 1'b1;
        cyc();
        clr_mon();
        arm_cap(8'd1, 4'd0);
        pix_valid = 1'b1;
        pix_data  = 32'hF0;
        cyc();
        pix_data  = 32'hF1;
        cyc();
        pix_valid = 1'b0;
        eof = 1'b1;
        cyc();
        eof = 1'b0;
        cyc();
        chk("rs_nobeats", beats.size(), 32'd0);
        chk("rs_still_busy", {31'd0, busy}, 32'd1);
        send_frame(2, 32'h900, 1'b0);
        chk("rs_done", {31'd0, done}, 32'd1);
        cyc();
        chk("rs_nbeats", beats.size(), 32'd2);
        chk("rs_b1", beats[1], 32'h901);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
